katadc_serial_config: RTL and testbench

Serial configuration engine for the KATADC ADC083000 3-wire control port. It accepts a 4-bit register address and 16-bit data word from the OPB controller's per-ADC config registers, serialises a 32-bit frame onto SCLK/SDATA/SEN_n, and reports completion through `config_idle`. One instance per ADC. It sits between the OPB register block, in the OPB_Clk domain, and the ADC board pins.

---
 rtl/katadc_serial_config.sv | 138 +++++++++++++
 tb/tb_katadc_serial_config.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/katadc_serial_config.sv
// Serial configuration engine for the KATADC ADC083000 3-wire control port.
// Shifts {12'h001, addr, data} MSB first on SCLK/SDATA framed by SEN_n, then holds and deselects.
module katadc_serial_config #(
    parameter int CLK_DIV = 8
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic [15:0] config_data,
    input  logic [3:0]  config_addr,
    input  logic        config_start,
    output logic        config_idle,
    output logic        adc_sclk,
    output logic        adc_sdata,
    output logic        adc_sen_n
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   shreg_q, shreg_d;
    logic          idle_q, idle_d;
    logic          sclk_q, sclk_d;
    logic          sdata_q, sdata_d;
    logic          sen_n_q, sen_n_d;
    logic          half_done;

    assign half_done = (div_cnt_q == DIV_LAST);

    // Pins are driven from the current state one cycle later, so every output is a clean flop.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        idle_d    = 1'b0;
        sclk_d    = 1'b0;
        sdata_d   = 1'b0;
        sen_n_d   = 1'b1;

        case (state_q)
            IDLE: begin
                idle_d = 1'b1;
                if (config_start) begin
                    state_d   = SHIFT;
                    shreg_d   = {12'h001, config_addr, config_data};
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end

            SHIFT: begin
                sen_n_d = 1'b0;
                sclk_d  = bit_cnt_q[0];
                sdata_d = shreg_q[31];
                if (half_done) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    // Advance data only after the high half so SDATA moves while SCLK is low.
                    if (bit_cnt_q[0]) begin
                        shreg_d = {shreg_q[30:0], 1'b0};
                    end
                    if (bit_cnt_q == 6'd63) begin
                        state_d   = HOLD;
                        bit_cnt_d = '0;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            HOLD: begin
                sen_n_d = 1'b0;
                if (half_done) begin
                    div_cnt_d = '0;
                    state_d   = GAP;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            GAP: begin
                if (half_done) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q[0]) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = 6'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            idle_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sen_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            idle_q    <= idle_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            sen_n_q   <= sen_n_d;
        end
    end

    assign config_idle = idle_q;
    assign adc_sclk    = sclk_q;
    assign adc_sdata   = sdata_q;
    assign adc_sen_n   = sen_n_q;

endmodule

// File: tb/tb_katadc_serial_config.sv
// Directed bench for katadc_serial_config: three instances (CLK_DIV 8, 2, 255) share one clock,
// and an ADC-side model captures SDATA on every SCLK rising edge.
module tb_katadc_serial_config;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  rst_w   = '0;
    logic [2:0]  start_w = '0;
    logic [3:0]  addr_w[3];
    logic [15:0] data_w[3];
    logic [2:0]  idle_w, sclk_w, sdata_w, sen_w;

    katadc_serial_config #(.CLK_DIV(8)) u_d8 (
        .OPB_Clk(clk), .OPB_Rst(rst_w[0]), .config_data(data_w[0]), .config_addr(addr_w[0]),
        .config_start(start_w[0]), .config_idle(idle_w[0]), .adc_sclk(sclk_w[0]),
        .adc_sdata(sdata_w[0]), .adc_sen_n(sen_w[0]));

    katadc_serial_config #(.CLK_DIV(2)) u_d2 (
        .OPB_Clk(clk), .OPB_Rst(rst_w[1]), .config_data(data_w[1]), .config_addr(addr_w[1]),
        .config_start(start_w[1]), .config_idle(idle_w[1]), .adc_sclk(sclk_w[1]),
        .adc_sdata(sdata_w[1]), .adc_sen_n(sen_w[1]));

    katadc_serial_config #(.CLK_DIV(255)) u_d255 (
        .OPB_Clk(clk), .OPB_Rst(rst_w[2]), .config_data(data_w[2]), .config_addr(addr_w[2]),
        .config_start(start_w[2]), .config_idle(idle_w[2]), .adc_sclk(sclk_w[2]),
        .adc_sdata(sdata_w[2]), .adc_sen_n(sen_w[2]));

    // ADC-side model: shift register clocked by SCLK rising, plus edge and width bookkeeping.
    int          rises[3], sen_falls[3], hi_len[3], lo_len[3], last_t[3];
    logic [31:0] cap[3];
    logic [2:0]  sclk_p = 3'b000;
    logic [2:0]  sen_p  = 3'b111;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!sen_w[i] && sen_p[i]) begin
                sen_falls[i]++;
                last_t[i] = cyc;
            end
            if (sclk_w[i] && !sclk_p[i]) begin
                cap[i]    = {cap[i][30:0], sdata_w[i]};
                rises[i]++;
                lo_len[i] = cyc - last_t[i];
                last_t[i] = cyc;
            end
            if (!sclk_w[i] && sclk_p[i]) begin
                hi_len[i] = cyc - last_t[i];
                last_t[i] = cyc;
            end
            sclk_p[i] = sclk_w[i];
            sen_p[i]  = sen_w[i];
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [3:0] a, input logic [15:0] d, input logic s);
        addr_w[idx]  = a;
        data_w[idx]  = d;
        start_w[idx] = s;
    endtask

    task automatic clearMonitor(input int idx);
        rises[idx]     = 0;
        sen_falls[idx] = 0;
        cap[idx]       = '0;
        hi_len[idx]    = 0;
        lo_len[idx]    = 0;
    endtask

    int   k, n;
    int   sen_first, sen_last, idle_first, idle_last;
    logic idle537;
    int   sr_t[2], ir_t[2], sf_t[2];
    logic [31:0] sr_cap[2];
    int   nsr, nir, nsf;
    logic prev_sen, prev_idle;

    initial begin
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i, 4'h0, 16'h0000, 1'b0);
            clearMonitor(i);
            last_t[i] = 0;
        end

        // Asynchronous reset asserted between clock edges must act before the next edge.
        #2 rst_w = 3'b111;
        #1;
        checkOutput("rst_idle", {31'd0, idle_w[0]}, 32'd1);
        checkOutput("rst_sen_n", {31'd0, sen_w[0]}, 32'd1);
        checkOutput("rst_sclk", {31'd0, sclk_w[0]}, 32'd0);
        checkOutput("rst_sdata", {31'd0, sdata_w[0]}, 32'd0);
        repeat (3) @(negedge clk);
        rst_w = 3'b000;
        repeat (3) @(negedge clk);

        // Single D=8 frame with a busy-time start that must be ignored.
        $display("[TB] single frame D=8");
        clearMonitor(0);
        applyStimulus(0, 4'hA, 16'h5A3C, 1'b1);
        k = cyc + 1;
        sen_first = -1; sen_last = -1; idle_first = -1; idle_last = -1; idle537 = 1'b0;
        while (cyc < k + 540) begin
            @(negedge clk);
            if (cyc == k)       applyStimulus(0, 4'hA, 16'h5A3C, 1'b0);
            if (cyc == k + 99)  applyStimulus(0, 4'h3, 16'hFFFF, 1'b1);
            if (cyc == k + 100) applyStimulus(0, 4'h3, 16'hFFFF, 1'b0);
            if (!sen_w[0]) begin
                if (sen_first < 0) sen_first = cyc - k;
                sen_last = cyc - k;
            end
            if (!idle_w[0]) begin
                if (idle_first < 0) idle_first = cyc - k;
                idle_last = cyc - k;
            end
            if (cyc == k + 537) idle537 = idle_w[0];
        end
        checkOutput("d8_word", cap[0], 32'h001A5A3C);
        checkOutput("d8_rises", rises[0], 32'd32);
        checkOutput("d8_sen_first", sen_first, 32'd1);
        checkOutput("d8_sen_last", sen_last, 32'd520);
        checkOutput("d8_idle_first", idle_first, 32'd1);
        checkOutput("d8_idle_last", idle_last, 32'd536);
        checkOutput("d8_idle_back", {31'd0, idle537}, 32'd1);
        checkOutput("d8_hi_len", hi_len[0], 32'd8);
        checkOutput("d8_lo_len", lo_len[0], 32'd8);
        repeat (300) @(negedge clk);
        checkOutput("busy_rises", rises[0], 32'd32);
        checkOutput("busy_frames", sen_falls[0], 32'd1);
        checkOutput("busy_word", cap[0], 32'h001A5A3C);

        // Held start at D=2 yields back-to-back frames separated by a full gap.
        $display("[TB] held start D=2");
        clearMonitor(1);
        applyStimulus(1, 4'h1, 16'h0001, 1'b1);
        k = cyc + 1;
        nsr = 0; nir = 0; nsf = 0;
        sr_t = '{0, 0}; ir_t = '{0, 0}; sf_t = '{0, 0}; sr_cap = '{32'd0, 32'd0};
        prev_sen = 1'b1; prev_idle = 1'b1;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (cyc == k + 135) applyStimulus(1, 4'h1, 16'h0001, 1'b0);
            if (sen_w[1] && !prev_sen && nsr < 2) begin
                sr_t[nsr] = cyc; sr_cap[nsr] = cap[1]; nsr++;
            end
            if (idle_w[1] && !prev_idle && nir < 2) begin
                ir_t[nir] = cyc; nir++;
            end
            if (!sen_w[1] && prev_sen && nsf < 2) begin
                sf_t[nsf] = cyc; nsf++;
            end
            prev_sen  = sen_w[1];
            prev_idle = idle_w[1];
        end
        checkOutput("held_word0", sr_cap[0], 32'h00110001);
        checkOutput("held_word1", sr_cap[1], 32'h00110001);
        checkOutput("held_sen_rise", sr_t[0] - k, 32'd131);
        checkOutput("held_gap", ir_t[0] - sr_t[0], 32'd4);
        checkOutput("held_restart", sf_t[1] - ir_t[0], 32'd1);
        checkOutput("held_rises", rises[1], 32'd64);
        checkOutput("held_frames", sen_falls[1], 32'd2);
        checkOutput("d2_hi_len", hi_len[1], 32'd2);
        checkOutput("d2_lo_len", lo_len[1], 32'd2);

        // Reset during a frame drops it; the next frame is complete.
        $display("[TB] reset mid-frame D=8");
        @(negedge clk);
        clearMonitor(0);
        applyStimulus(0, 4'hA, 16'h5A3C, 1'b1);
        @(negedge clk);
        applyStimulus(0, 4'hA, 16'h5A3C, 1'b0);
        n = 0;
        while (rises[0] < 10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #2 rst_w[0] = 1'b1;
        #1;
        checkOutput("abort_idle", {31'd0, idle_w[0]}, 32'd1);
        checkOutput("abort_sen_n", {31'd0, sen_w[0]}, 32'd1);
        checkOutput("abort_sclk", {31'd0, sclk_w[0]}, 32'd0);
        checkOutput("abort_sdata", {31'd0, sdata_w[0]}, 32'd0);
        @(negedge clk);
        rst_w[0] = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("abort_rises", rises[0], 32'd10);
        checkOutput("abort_frames", sen_falls[0], 32'd1);
        clearMonitor(0);
        applyStimulus(0, 4'h5, 16'hC3A1, 1'b1);
        @(negedge clk);
        applyStimulus(0, 4'h5, 16'hC3A1, 1'b0);
        repeat (560) @(negedge clk);
        checkOutput("after_rst_word", cap[0], 32'h0015C3A1);
        checkOutput("after_rst_rises", rises[0], 32'd32);

        // Widest divider.
        $display("[TB] single frame D=255");
        clearMonitor(2);
        applyStimulus(2, 4'h7, 16'h1234, 1'b1);
        @(negedge clk);
        applyStimulus(2, 4'h7, 16'h1234, 1'b0);
        repeat (67 * 255 + 20) @(negedge clk);
        checkOutput("d255_word", cap[2], 32'h00171234);
        checkOutput("d255_rises", rises[2], 32'd32);
        checkOutput("d255_hi_len", hi_len[2], 32'd255);
        checkOutput("d255_lo_len", lo_len[2], 32'd255);
        checkOutput("d255_idle", {31'd0, idle_w[2]}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
